// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_pkg
// Description : Shared types and default constants for the neuron MAC stage.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

  // Default sizing for one classifier neuron
  localparam int DATA_W_DEF   = 8;
  localparam int ACC_W_DEF    = 20;
  localparam int N_INPUTS_DEF = 784;

  // Signed clamp limits for the default accumulator width
  localparam logic [ACC_W_DEF-1:0] SAT_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] SAT_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  // Image-level control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/acc_adder.sv
`default_nettype none
// ============================================================================
// Module      : acc_adder
// Description : ACC_W-bit ripple-carry adder chained from fa_4b slices, with
//               a signed-overflow flag (equal operand signs, result differs).
//               ACC_W must be a multiple of 4.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_adder #(
  parameter int ACC_W = 20
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             c_in,
  output logic [ACC_W-1:0] s,
  output logic             c_out,
  output logic             overflow
);

  localparam int NSLICE = ACC_W / 4;

  logic [NSLICE:0] carry;

  assign carry[0] = c_in;

  // Chain the 4-bit slices; each slice's carry feeds the next
  generate
    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
      fa_4b u_fa (
        .a    (a[4*k +: 4]),
        .b    (b[4*k +: 4]),
        .c_in (carry[k]),
        .s    (s[4*k +: 4]),
        .c_out(carry[k+1])
      );
    end
  endgenerate

  assign c_out    = carry[NSLICE];
  assign overflow = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);

endmodule
`default_nettype wire

// File: rtl/fa_4b.sv
`default_nettype none
// ============================================================================
// Module      : fa_4b
// Description : 4-bit ripple-carry slice built from single-bit full adders.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [4:0] c;

  assign c[0] = c_in;

  // One full adder per bit, carry rippling upward
  generate
    for (genvar i = 0; i < 4; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign c_out = c[4];

endmodule
`default_nettype wire

// File: rtl/neuron_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_acc
// Description : Per-neuron multiply-accumulate stage. Loads bias on start,
//               accumulates N_INPUTS pixel*weight products, then holds the
//               signed sum on acc_out until the downstream stage accepts it.
//               Optional build macro: ACC_SATURATE_EN (clamp instead of wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac_acc
  import neuron_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int N_INPUTS = N_INPUTS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ACC_W-1:0]  bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pixel,
  input  logic [DATA_W-1:0] weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy
);

  localparam int PROD_W = 2 * DATA_W + 1;
  localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  state_t state, state_next;

  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_next;
  logic [ACC_W-1:0]         addend;
  logic [ACC_W-1:0]         sum;
  logic [CNT_W-1:0]         count;
  logic                     sum_cout;
  logic                     sum_ovf;
  logic                     beat;
  logic signed [PROD_W-1:0] pix_ext;
  logic signed [PROD_W-1:0] wgt_ext;
  logic signed [PROD_W-1:0] prod;

  assign beat = (state == ACCUM) && in_valid;

  // Pixel is unsigned, weight is two's complement; product fits PROD_W exactly
  assign pix_ext = {{(PROD_W-DATA_W){1'b0}}, pixel};
  assign wgt_ext = {{(PROD_W-DATA_W){weight[DATA_W-1]}}, weight};
  assign prod    = pix_ext * wgt_ext;

  // Bring the product to accumulator width. When the accumulator is narrower
  // than the product, saturating builds clamp the product first so that a
  // huge product cannot alias to the opposite sign and dodge the adder's
  // overflow detection.
  generate
    if (ACC_W > PROD_W) begin : g_prod_sext
      assign addend = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end else begin : g_prod_narrow
`ifdef ACC_SATURATE_EN
      localparam logic signed [PROD_W-1:0] PROD_HI =
        {{(PROD_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
      localparam logic signed [PROD_W-1:0] PROD_LO =
        {{(PROD_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
      // Clamp an out-of-range product to the accumulator's signed range
      always_comb begin
        addend = prod[ACC_W-1:0];
        if (prod > PROD_HI) begin
          addend = PROD_HI[ACC_W-1:0];
        end else if (prod < PROD_LO) begin
          addend = PROD_LO[ACC_W-1:0];
        end
      end
`else
      logic unused_prod_hi;
      assign addend         = prod[ACC_W-1:0];
      assign unused_prod_hi = ^prod[PROD_W-1:ACC_W];
`endif
    end
  endgenerate

  acc_adder #(
    .ACC_W(ACC_W)
  ) u_acc_adder (
    .a       (acc),
    .b       (addend),
    .c_in    (1'b0),
    .s       (sum),
    .c_out   (sum_cout),
    .overflow(sum_ovf)
  );

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic unused_cout;
  assign unused_cout = sum_cout;

  // On overflow, pin to the rail matching the (shared) operand sign
  always_comb begin
    acc_next = sum;
    if (sum_ovf) begin
      acc_next = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  logic unused_add_flags;
  assign unused_add_flags = sum_cout ^ sum_ovf;

  // Plain modulo-2^ACC_W accumulation
  always_comb begin
    acc_next = sum;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    acc_out    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (count == LAST_IDX)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        acc_out   = acc;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Accumulator and beat counter: bias load on start, update on each beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else if ((state == IDLE) && start) begin
      acc   <= bias;
      count <= '0;
    end else if (beat) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac_acc
// Description : Directed self-checking bench for neuron_mac_acc. Instance A
//               uses ACC_W=20/N_INPUTS=4; instance B uses ACC_W=12/N_INPUTS=2
//               for the wrap/saturation corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac_acc;

  logic        clk = 1'b0;
  logic        reset;

  logic        start_a, in_valid_a, out_ready_a;
  logic [19:0] bias_a;
  logic [7:0]  pixel_a, weight_a;
  logic        in_ready_a, out_valid_a, busy_a;
  logic [19:0] acc_out_a;

  logic        start_b, in_valid_b, out_ready_b;
  logic [11:0] bias_b;
  logic [7:0]  pixel_b, weight_b;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [11:0] acc_out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_mac_acc #(.DATA_W(8), .ACC_W(20), .N_INPUTS(4)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .start    (start_a),
    .bias     (bias_a),
    .in_valid (in_valid_a),
    .in_ready (in_ready_a),
    .pixel    (pixel_a),
    .weight   (weight_a),
    .out_valid(out_valid_a),
    .out_ready(out_ready_a),
    .acc_out  (acc_out_a),
    .busy     (busy_a)
  );

  neuron_mac_acc #(.DATA_W(8), .ACC_W(12), .N_INPUTS(2)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .start    (start_b),
    .bias     (bias_b),
    .in_valid (in_valid_b),
    .in_ready (in_ready_b),
    .pixel    (pixel_b),
    .weight   (weight_b),
    .out_valid(out_valid_b),
    .out_ready(out_ready_b),
    .acc_out  (acc_out_b),
    .busy     (busy_b)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a_img(input logic [19:0] b);
    start_a = 1'b1;
    bias_a  = b;
    step();
    start_a = 1'b0;
  endtask

  task automatic beat_a(input logic [7:0] p, input logic [7:0] w);
    in_valid_a = 1'b1;
    pixel_a    = p;
    weight_a   = w;
    step();
    in_valid_a = 1'b0;
  endtask

  task automatic beat_b(input logic [7:0] p, input logic [7:0] w);
    in_valid_b = 1'b1;
    pixel_b    = p;
    weight_b   = w;
    step();
    in_valid_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start_a = 0; in_valid_a = 0; out_ready_a = 0; bias_a = '0; pixel_a = '0; weight_a = '0;
    start_b = 0; in_valid_b = 0; out_ready_b = 0; bias_b = '0; pixel_b = '0; weight_b = '0;
    step();
    step();

    // Reset state
    check("rst_in_ready", in_ready_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_acc_out", acc_out_a, 0);
    reset = 1'b0;
    step();

    // in_valid ignored while idle
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    check("idle_busy", busy_a, 0);

    // Reset during ACCUM: abort immediately
    start_a_img(20'd10);
    check("accum_in_ready", in_ready_a, 1);
    check("accum_busy", busy_a, 1);
    beat_a(8'd1, 8'd1);
    beat_a(8'd1, 8'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_in_ready", in_ready_a, 0);
    check("abort_out_valid", out_valid_a, 0);
    check("abort_acc_out", acc_out_a, 0);
    check("abort_busy", busy_a, 0);
    step();
    reset = 1'b0;
    step();

    start_a_img(20'd0);
    for (int i = 0; i < 4; i++) beat_a(8'd1, 8'd1);
    check("post_abort_valid", out_valid_a, 1);
    check("post_abort_sum", $signed(acc_out_a), 4);
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;

    // Basic image: 10 + 6 - 5 + 0 + 255 = 266
    start_a_img(20'd10);
    beat_a(8'd2, 8'd3);
    beat_a(8'd5, 8'hFF);
    beat_a(8'd0, 8'd127);
    check("basic_not_yet_valid", out_valid_a, 0);
    beat_a(8'd255, 8'd1);
    check("basic_valid", out_valid_a, 1);
    check("basic_in_ready_done", in_ready_a, 0);
    check("basic_sum", $signed(acc_out_a), 266);
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;
    check("basic_released", out_valid_a, 0);
    check("basic_acc_out_idle", acc_out_a, 0);
    check("basic_idle_busy", busy_a, 0);

    // Backpressure + start during ACCUM: 2 + 12 + 30 + 56 = 100
    start_a_img(20'd0);
    beat_a(8'd1, 8'd2);
    start_a = 1'b1;            // ignored mid-image
    bias_a  = 20'd999;
    step();
    start_a = 1'b0;
    beat_a(8'd3, 8'd4);
    step();
    beat_a(8'd5, 8'd6);
    step();
    check("bp_still_accum", in_ready_a, 1);
    check("bp_no_early_valid", out_valid_a, 0);
    beat_a(8'd7, 8'd8);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", out_valid_a, 1);
      check("bp_hold_sum", $signed(acc_out_a), 100);
      step();
    end

    // start together with out_ready in DONE: return to IDLE, no restart
    start_a     = 1'b1;
    out_ready_a = 1'b1;
    step();
    start_a     = 1'b0;
    out_ready_a = 1'b0;
    check("done_start_out_valid", out_valid_a, 0);
    check("done_start_busy", busy_a, 0);
    step();
    step();
    check("done_start_no_restart", busy_a, 0);
    check("done_start_in_ready", in_ready_a, 0);

    // Narrow accumulator, positive overflow
    start_b = 1'b1;
    bias_b  = 12'd2000;
    step();
    start_b = 1'b0;
    beat_b(8'd255, 8'd127);
    beat_b(8'd255, 8'd127);
    check("narrow_pos_valid", out_valid_b, 1);
`ifdef ACC_SATURATE_EN
    check("narrow_pos_sum", $signed(acc_out_b), 2047);
`else
    check("narrow_pos_sum", $signed(acc_out_b), 1234);
`endif
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;

    // Narrow accumulator, negative overflow
    start_b = 1'b1;
    bias_b  = 12'hFFF - 12'd1999;   // -2000
    step();
    start_b = 1'b0;
    beat_b(8'd255, 8'h80);
    beat_b(8'd255, 8'h80);
    check("narrow_neg_valid", out_valid_b, 1);
`ifdef ACC_SATURATE_EN
    check("narrow_neg_sum", $signed(acc_out_b), -2048);
`else
    check("narrow_neg_sum", $signed(acc_out_b), -1744);
`endif
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
    check("narrow_released", out_valid_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/neuron_mac_acc.md
Name: neuron_mac_acc

Overview:
Sequential multiply-accumulate stage for one neuron of the digit classifier. Consumes a stream of pixel/weight pairs, forms products, and sums them into a bias-initialised accumulator through a ripple-carry adder chain built from the team's full-adder cells. Presents one signed pre-activation sum per image to the downstream activation/argmax stage.

Parameters:
DATA_W, 8, width of pixel (unsigned) and weight (signed two's complement)
ACC_W, 20, accumulator and result width (signed)
N_INPUTS, 784, number of pixel/weight beats per image

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin new image; sampled only in IDLE
bias  input  ACC_W  signed bias, loaded into accumulator on accepted start
in_valid  input  1  pixel/weight beat valid
in_ready  output  1  stage accepts a beat
pixel  input  DATA_W  unsigned pixel value
weight  input  DATA_W  signed weight
out_valid  output  1  acc_out holds final sum
out_ready  input  1  downstream accepts result
acc_out  output  ACC_W  signed accumulated sum
busy  output  1  high in ACCUM or DONE

Behaviour:
- Clocking: single clock domain, clk. reset is asynchronous and active-high (fixed). While reset is high: state=IDLE, acc=0, count=0, in_ready=0, out_valid=0, busy=0, acc_out=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready=0. If start=1, then at the clock edge acc<=bias, count<=0, and the FSM moves to ACCUM. While in IDLE, in_valid is ignored.
- ACCUM: in_ready=1. A beat transfers when in_valid and in_ready are both high. On each transfer:
  - acc <= acc + sext(pixel*weight). The product is computed as zero-extended pixel times sign-extended weight, giving a 2*DATA_W+1-bit signed value, then sign-extended to ACC_W.
  - count increments by 1.
  - When the transfer occurs with count==N_INPUTS-1, the FSM moves to DONE.
  - No transfer means acc and count hold.
- DONE: in_ready=0, out_valid=1, acc_out=acc (held stable). When out_ready=1, the FSM returns to IDLE and out_valid drops the next cycle.
- Latency: out_valid rises the cycle after the last beat transfers. One beat per cycle maximum throughput. Result is visible 1 cycle after the final edge.
- start while in ACCUM or DONE: ignored, with no restart. start in the same cycle as the DONE->IDLE transition: ignored, and must be reasserted in IDLE.
- Arithmetic without the optional feature: two's-complement wrap modulo 2^ACC_W. The adder carry-out is discarded.
- Reset mid-image: immediate abort to IDLE with all state cleared. No partial result is emitted.
- acc_out reads 0 outside DONE.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- When defined: the signed overflow of each accumulate step is detected (operand signs equal, result sign differs). On overflow, acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) according to the operand sign, and remains eligible to move back from the clamp on subsequent beats.
- When undefined: pure wrap, and no overflow logic is synthesised.

Decomposition:
- Package neuron_pkg holds:
  - the state enum typedef (IDLE/ACCUM/DONE)
  - default DATA_W/ACC_W/N_INPUTS constants
  - the SAT_MAX/SAT_MIN localparams derived from ACC_W
- Sub-module acc_adder: an ACC_W-bit ripple-carry adder instantiating fa_4b slices (ACC_W multiple of 4). It exposes a, b, c_in, s, c_out, plus an overflow output for the saturation path.

Test Plan:
- Reset during ACCUM (N_INPUTS=4, two beats sent) -> in_ready=0, out_valid=0, acc_out=0 immediately. A subsequent start with bias=0 and beats (1,1)x4 gives acc_out=4.
- N_INPUTS=4, bias=10, beats (pixel,weight)=(2,3),(5,-1),(0,127),(255,1) -> out_valid one cycle after the 4th beat, acc_out=10+6-5+0+255=266.
- Backpressure: in_valid toggled 1,0,1,0 during ACCUM and out_ready held 0 for 5 cycles in DONE -> count advances only on valid cycles, acc_out stays stable, and out_valid stays high until out_ready=1.
- start pulsed during ACCUM and together with out_ready in DONE -> no restart; FSM returns to IDLE and waits for a new start.
- ACC_W=12, N_INPUTS=2, bias=2000, beats (255,127)x2: without ACC_SATURATE_EN, acc_out=(2000+64770) mod 4096 as signed = 1234. With the macro defined, acc_out=2047.
- Negative saturation: ACC_W=12, bias=-2000, beats (255,-128)x2 -> with ACC_SATURATE_EN, acc_out=-2048.
